// File: rtl/storage_port_arbiter.sv
// storage_port_arbiter
//   Per-cycle request/grant arbiter in front of the single-port matrix storage.
//   Channels: ch0 = input, ch1 = display, ch2 = calc (N_CH total).
//   Supports round-robin or fixed priority, burst locking with a forced-release
//   timeout, and read-data return tagging to the issuing channel.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   i_req/i_we/i_lock per-channel request, write qualifier, burst-lock request
//   i_addr/i_wdata   per-channel address/write data, ch k at [k*W +: W]
//   o_gnt            one-hot grant, combinational in the request cycle
//   o_rvalid/o_rdata read return, o_rvalid tagged per channel, data shared
//   o_mem_*          storage command from the granted channel
//   i_mem_rdata      storage read data, RD_LAT cycles after address
//   o_lock_timeout   1-cycle pulse in the cycle a lock is forcibly released
module storage_port_arbiter #(
  parameter int N_CH     = 3,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int RR_MODE  = 1,
  parameter int LOCK_MAX = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          i_req,
  input  logic [N_CH-1:0]          i_we,
  input  logic [N_CH-1:0]          i_lock,
  input  logic [N_CH*ADDR_W-1:0]   i_addr,
  input  logic [N_CH*DATA_W-1:0]   i_wdata,
  output logic [N_CH-1:0]          o_gnt,
  output logic [N_CH-1:0]          o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_mem_we,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  output logic                     o_lock_timeout
);

  localparam int PTR_W = $clog2(N_CH);
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic {ARB, LOCKED} state_e;

  // Registered state
  state_e                          state_q, state_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [PTR_W-1:0]                owner_q, owner_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [N_CH-1:0]                 block_q, block_d;   // re-lock inhibited until i_lock seen low
  logic [RD_LAT-1:0][N_CH-1:0]     tag_pipe_q, tag_pipe_d;

  // Per-channel views of the packed buses
  logic [N_CH-1:0][ADDR_W-1:0]     ch_addr;
  logic [N_CH-1:0][DATA_W-1:0]     ch_wdata;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_addr[k]  = i_addr[k*ADDR_W +: ADDR_W];
    assign ch_wdata[k] = i_wdata[k*DATA_W +: DATA_W];
  end

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] k);
    return (int'(k) == N_CH - 1) ? '0 : k + 1'b1;
  endfunction

  // Grant selection
  logic [N_CH-1:0]  gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [PTR_W-1:0] scan_c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan_c  = '0;
    if (state_q == LOCKED) begin
      // Everyone but the owner is blocked; an idle owner leaves the port idle.
      if (i_req[owner_q]) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (RR_MODE != 0) scan_c = PTR_W'((int'(ptr_q) + i) % N_CH);
        else              scan_c = PTR_W'(i);
        if (!gnt_any && i_req[scan_c]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_c;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // Storage command: AND-OR mux on the one-hot grant, zero when idle
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt[k]) begin
        mem_addr  = mem_addr | ch_addr[k];
        mem_wdata = mem_wdata | ch_wdata[k];
      end
    end
  end

  // FSM next state, lock counter, pointer and re-lock inhibit
  logic timeout;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    // Any channel observed with i_lock low is allowed to lock again.
    block_d = block_q & i_lock;
    unique case (state_q)
      ARB: begin
        if (gnt_any) begin
          if (RR_MODE != 0) ptr_d = wrap_inc(gnt_idx);
          if (i_lock[gnt_idx] && !block_q[gnt_idx]) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
            cnt_d   = '0;
          end
        end
      end
      LOCKED: begin
        if (cnt_q == CNT_LAST) begin
          // Forced release: hand priority to the next channel and keep the
          // owner from grabbing the lock again while it still holds i_lock.
          timeout          = 1'b1;
          state_d          = ARB;
          ptr_d            = wrap_inc(owner_q);
          block_d[owner_q] = i_lock[owner_q];
        end else if (!i_lock[owner_q]) begin
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Read tag pipeline: reads push their one-hot, writes/idle push zero
  always_comb begin
    tag_pipe_d    = tag_pipe_q;
    tag_pipe_d[0] = gnt & ~i_we;
    for (int s = 1; s < RD_LAT; s++) tag_pipe_d[s] = tag_pipe_q[s-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      block_q    <= '0;
      tag_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      block_q    <= block_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  // Outputs are forced quiet during reset so a read issued just before reset
  // never surfaces as o_rvalid.
  assign o_gnt          = rst ? '0   : gnt;
  assign o_mem_we       = rst ? 1'b0 : |(gnt & i_we);
  assign o_mem_addr     = rst ? '0   : mem_addr;
  assign o_mem_wdata    = rst ? '0   : mem_wdata;
  assign o_lock_timeout = rst ? 1'b0 : timeout;
  assign o_rvalid       = rst ? '0   : tag_pipe_q[RD_LAT-1];
  assign o_rdata        = i_mem_rdata;

endmodule

// File: tb/tb_storage_port_arbiter.sv
// Bench for storage_port_arbiter: two instances share stimulus.
//   inst 0: round-robin, RD_LAT=1, LOCK_MAX=8
//   inst 1: fixed priority, RD_LAT=2, LOCK_MAX=8
// Directed scenarios followed by random traffic, all checked against a
// cycle-level reference model plus explicit expected values.
module tb_storage_port_arbiter;
  localparam int N  = 3;
  localparam int LM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, we, lock;
  logic [8:0]  addr  [3];
  logic [31:0] wdata [3];
  logic [26:0] addr_p;
  logic [95:0] wdata_p;
  assign addr_p  = {addr[2], addr[1], addr[0]};
  assign wdata_p = {wdata[2], wdata[1], wdata[0]};

  logic [2:0]  gnt [2], rvalid [2];
  logic [31:0] rdata [2], mwdata [2];
  logic        mwe [2], to [2];
  logic [8:0]  maddr [2];
  logic [31:0] mrd0, mrd1, rd1_q;

  storage_port_arbiter #(.N_CH(3), .ADDR_W(9), .DATA_W(32), .RD_LAT(1), .RR_MODE(1), .LOCK_MAX(LM)) u_rr (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_lock(lock), .i_addr(addr_p), .i_wdata(wdata_p),
    .o_gnt(gnt[0]), .o_rvalid(rvalid[0]), .o_rdata(rdata[0]), .o_mem_we(mwe[0]), .o_mem_addr(maddr[0]),
    .o_mem_wdata(mwdata[0]), .i_mem_rdata(mrd0), .o_lock_timeout(to[0]));

  storage_port_arbiter #(.N_CH(3), .ADDR_W(9), .DATA_W(32), .RD_LAT(2), .RR_MODE(0), .LOCK_MAX(LM)) u_fp (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_lock(lock), .i_addr(addr_p), .i_wdata(wdata_p),
    .o_gnt(gnt[1]), .o_rvalid(rvalid[1]), .o_rdata(rdata[1]), .o_mem_we(mwe[1]), .o_mem_addr(maddr[1]),
    .o_mem_wdata(mwdata[1]), .i_mem_rdata(mrd1), .o_lock_timeout(to[1]));

  // Storage models: 1-cycle and 2-cycle read latency
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  always @(posedge clk) begin
    if (mwe[0]) mem0[maddr[0]] <= mwdata[0];
    mrd0 <= mem0[maddr[0]];
  end
  always @(posedge clk) begin
    if (mwe[1]) mem1[maddr[1]] <= mwdata[1];
    rd1_q <= mem1[maddr[1]];
    mrd1  <= rd1_q;
  end

  // Reference model state, per instance
  bit          m_locked [2];
  int          m_owner  [2];
  int          m_cnt    [2];
  int          m_ptr    [2];
  bit          m_blk    [2][3];
  int          p_ch     [2][2];
  logic [31:0] p_dat    [2][2];
  bit          p_known  [2][2];
  logic [31:0] gmem     [2][512];
  bit          gknown   [2][512];
  int          e_g      [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lat(input int m);
    return (m == 0) ? 1 : 2;
  endfunction

  // Expected outputs for the current inputs, compared against the DUT.
  task automatic eval(input int m);
    int g;
    bit eto;
    int rc;
    g = -1;
    eto = 1'b0;
    if (!rst) begin
      if (m_locked[m]) begin
        if (req[m_owner[m]]) g = m_owner[m];
        eto = (m_cnt[m] == LM - 1);
      end else begin
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m == 0) ? (m_ptr[m] + i) % N : i;
          if (g < 0 && req[c]) g = c;
        end
      end
    end
    e_g[m] = g;
    chk($sformatf("gnt%0d", m),   32'(gnt[m]),   (g >= 0) ? (32'd1 << g) : 32'd0);
    chk($sformatf("we%0d", m),    32'(mwe[m]),   (g >= 0) ? 32'(we[g]) : 32'd0);
    chk($sformatf("addr%0d", m),  32'(maddr[m]), (g >= 0) ? 32'(addr[g]) : 32'd0);
    chk($sformatf("wdata%0d", m), mwdata[m],     (g >= 0) ? wdata[g] : 32'd0);
    chk($sformatf("tmo%0d", m),   32'(to[m]),    32'(eto));
    rc = rst ? -1 : p_ch[m][lat(m)-1];
    chk($sformatf("rvalid%0d", m), 32'(rvalid[m]), (rc >= 0) ? (32'd1 << rc) : 32'd0);
    if (rc >= 0 && p_known[m][lat(m)-1])
      chk($sformatf("rdata%0d", m), rdata[m], p_dat[m][lat(m)-1]);
  endtask

  // Advance the model by one clock edge.
  task automatic commit(input int m);
    int g;
    bit old_blk [3];
    g = e_g[m];
    if (rst) begin
      m_locked[m] = 0; m_owner[m] = 0; m_cnt[m] = 0; m_ptr[m] = 0;
      for (int k = 0; k < N; k++) m_blk[m][k] = 0;
      for (int s = 0; s < 2; s++) p_ch[m][s] = -1;
      return;
    end
    for (int s = lat(m) - 1; s >= 1; s--) begin
      p_ch[m][s] = p_ch[m][s-1]; p_dat[m][s] = p_dat[m][s-1]; p_known[m][s] = p_known[m][s-1];
    end
    if (g >= 0 && !we[g]) begin
      p_ch[m][0] = g; p_dat[m][0] = gmem[m][addr[g]]; p_known[m][0] = gknown[m][addr[g]];
    end else begin
      p_ch[m][0] = -1;
    end
    if (g >= 0 && we[g]) begin
      gmem[m][addr[g]] = wdata[g]; gknown[m][addr[g]] = 1;
    end
    for (int k = 0; k < N; k++) begin
      old_blk[k] = m_blk[m][k];
      if (!lock[k]) m_blk[m][k] = 0;
    end
    if (m_locked[m]) begin
      if (m_cnt[m] == LM - 1) begin
        m_locked[m] = 0;
        m_ptr[m] = (m_owner[m] + 1) % N;
        if (lock[m_owner[m]]) m_blk[m][m_owner[m]] = 1;
      end else if (!lock[m_owner[m]]) begin
        m_locked[m] = 0;
      end else begin
        m_cnt[m]++;
      end
    end else if (g >= 0) begin
      if (m == 0) m_ptr[m] = (g + 1) % N;
      if (lock[g] && !old_blk[g]) begin
        m_locked[m] = 1; m_owner[m] = g; m_cnt[m] = 0;
      end
    end
  endtask

  task automatic step();
    eval(0); eval(1); commit(0); commit(1);
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0; lock = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  logic [2:0] exp1 [6];
  bit         hold [3];

  initial begin
    exp1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int m = 0; m < 2; m++) for (int s = 0; s < 2; s++) p_ch[m][s] = -1;
    for (int k = 0; k < 3; k++) begin addr[k] = '0; wdata[k] = '0; hold[k] = 0; end
    rst = 1'b1; req = '0; we = '0; lock = '0;
    @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt[0]), 32'd0);
    chk("rst_rvalid", 32'(rvalid[1]), 32'd0);
    step();
    do_reset();

    // All three reading continuously: rotation vs. starvation
    req = 3'b111; we = 3'b000;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_seq", 32'(gnt[0]), 32'(exp1[i]));
      chk("fp_seq", 32'(gnt[1]), 32'd1);
      chk("rr_rv", 32'(rvalid[0]), (i == 0) ? 32'd0 : 32'(exp1[i-1]));
      step();
    end

    // ch2 locked write burst while ch0 waits
    do_reset();
    req = 3'b100; we = 3'b100; lock = 3'b100; addr[2] = 9'h20; wdata[2] = $urandom;
    #1; chk("lk_first0", 32'(gnt[0]), 32'd4); chk("lk_first1", 32'(gnt[1]), 32'd4);
    step();
    for (int i = 1; i < 5; i++) begin
      req = 3'b101; lock = (i < 4) ? 3'b100 : 3'b000; addr[2] = 9'(9'h20 + i); wdata[2] = $urandom;
      #1; chk("lk_hold0", 32'(gnt[0]), 32'd4); chk("lk_hold1", 32'(gnt[1]), 32'd4);
      step();
    end
    #1; chk("lk_drop0", 32'(gnt[0]), 32'd1); chk("lk_drop1", 32'(gnt[1]), 32'd1);
    step();

    // ch1 holds its lock indefinitely -> forced release on the 8th locked cycle
    do_reset();
    req = 3'b110; we = 3'b000; lock = 3'b010;
    #1; chk("to_grab", 32'(gnt[0]), 32'd2);
    step();
    for (int j = 1; j <= LM; j++) begin
      #1;
      chk("to_own", 32'(gnt[0]), 32'd2);
      chk("to_pulse", 32'(to[0]), (j == LM) ? 32'd1 : 32'd0);
      step();
    end
    #1; chk("to_next", 32'(gnt[0]), 32'd4); chk("to_fp", 32'(gnt[1]), 32'd2);
    step();
    tick(); tick();
    lock = 3'b000; tick();
    lock = 3'b010; tick(); tick(); tick();

    // Write then read-back on the same address from another channel
    do_reset();
    req = 3'b001; we = 3'b001; addr[0] = 9'h05; wdata[0] = 32'hDEADBEEF;
    tick();
    req = 3'b010; we = 3'b000; addr[1] = 9'h05;
    tick();
    req = 3'b000;
    #1; chk("rb_rv0", 32'(rvalid[0]), 32'd2); chk("rb_dat0", rdata[0], 32'hDEADBEEF);
    step();
    #1; chk("rb_rv1", 32'(rvalid[1]), 32'd2); chk("rb_dat1", rdata[1], 32'hDEADBEEF);
    step();

    // Reset right after a read grant: in-flight reads are dropped
    do_reset();
    req = 3'b010; we = 3'b000; addr[1] = 9'h03;
    tick();
    rst = 1'b1; req = 3'b000;
    #1; chk("rf_rv0", 32'(rvalid[0]), 32'd0); chk("rf_rv1a", 32'(rvalid[1]), 32'd0);
    step();
    rst = 1'b0; req = 3'b111;
    #1; chk("rf_rv1b", 32'(rvalid[1]), 32'd0); chk("rf_gnt0", 32'(gnt[0]), 32'd1); chk("rf_gnt1", 32'(gnt[1]), 32'd1);
    step();

    // Random traffic with persistent lock intents and occasional reset
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 7) == 0) hold[k] = ~hold[k];
        lock[k]  = hold[k];
        req[k]   = ($urandom_range(0, 3) != 0);
        we[k]    = 1'($urandom_range(0, 1));
        addr[k]  = 9'($urandom_range(0, 15));
        wdata[k] = $urandom;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
